// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module : ssd_pkg
// Brief  : Shared glyph codes and segment types for the seven-segment driver.
// Rev    : 1.0  initial release
// ============================================================================
package ssd_pkg;

  typedef logic [6:0] seg_t;  // {a,b,c,d,e,f,g}, active-low

  localparam seg_t        SEG_OFF     = 7'h7F;
  localparam logic [4:0]  GLYPH_BLANK = 5'h10;
  localparam logic [4:0]  GLYPH_L     = 5'h11;
  localparam logic [4:0]  GLYPH_R     = 5'h12;
  localparam logic [4:0]  GLYPH_DASH  = 5'h13;
  localparam logic [4:0]  GLYPH_P     = 5'h14;

  localparam int          IDX_W       = 3;

endpackage
`default_nettype wire

// File: rtl/ssd_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module : ssd_scan_driver_if
// Brief  : Game-logic side glyph bus and board-facing scan outputs.
// Rev    : 1.0  initial release
// ============================================================================
interface ssd_scan_driver_if
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) ();

  logic [5*NUM_DIGITS-1:0] glyph_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic [3:0]              brightness;
  logic                    load;
  logic [NUM_DIGITS-1:0]   An;
  logic [7:0]              Cathodes;
  logic [IDX_W-1:0]        scan_idx;
  logic                    frame_tick;

  modport master (
    output glyph_in, dp_in, digit_en, blink_en, brightness, load,
    input  An, Cathodes, scan_idx, frame_tick
  );

  modport slave (
    input  glyph_in, dp_in, digit_en, blink_en, brightness, load,
    output An, Cathodes, scan_idx, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/ssd_glyph_decoder.sv
`default_nettype none
// ============================================================================
// Module : ssd_glyph_decoder
// Brief  : 5-bit glyph code to active-low {a..g} segment pattern.
// Rev    : 1.0  initial release
// ============================================================================
module ssd_glyph_decoder
  import ssd_pkg::*;
(
  input  wire logic [4:0] i_glyph,
  output seg_t            o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_glyph)
      5'h00:      o_seg = 7'b0000001;
      5'h01:      o_seg = 7'b1001111;
      5'h02:      o_seg = 7'b0010010;
      5'h03:      o_seg = 7'b0000110;
      5'h04:      o_seg = 7'b1001100;
      5'h05:      o_seg = 7'b0100100;
      5'h06:      o_seg = 7'b0100000;
      5'h07:      o_seg = 7'b0001111;
      5'h08:      o_seg = 7'b0000000;
      5'h09:      o_seg = 7'b0000100;
      5'h0A:      o_seg = 7'b0001000;
      5'h0B:      o_seg = 7'b1100000;
      5'h0C:      o_seg = 7'b0110001;
      5'h0D:      o_seg = 7'b1000010;
      5'h0E:      o_seg = 7'b0110000;
      5'h0F:      o_seg = 7'b0111000;
      GLYPH_L:    o_seg = 7'b1110001;
      GLYPH_R:    o_seg = 7'b1111010;
      GLYPH_DASH: o_seg = 7'b1111110;
      GLYPH_P:    o_seg = 7'b0011000;
      default:    o_seg = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : ssd_scan_driver
// Brief  : N-digit double-buffered seven-segment scanner with PWM and blink.
// Rev    : 1.0  initial release
// ============================================================================
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV_BITS  = 17,
  parameter int BLANK_CYCLES   = 4,
  parameter int BLINK_DIV_BITS = 25
) (
  input  wire logic        ClkPort,
  input  wire logic        Reset_n,
  ssd_scan_driver_if.slave bus
);

  typedef struct packed {
    logic [5*NUM_DIGITS-1:0] glyph;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   blink;
    logic [3:0]              bright;
  } disp_set_t;

  localparam disp_set_t c_set_reset = '{
    glyph:  {NUM_DIGITS{GLYPH_BLANK}},
    dp:     '0,
    en:     '0,
    blink:  '0,
    bright: '0
  };
  localparam logic [SCAN_DIV_BITS-1:0] c_dwell_max = '1;
  localparam logic [IDX_W-1:0]         c_last_idx  = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0]  r_dwell_cnt;
  logic [IDX_W-1:0]          r_cnt_idx;
  logic [BLINK_DIV_BITS-1:0] r_blink_cnt;
  logic                      r_blink_phase;
  disp_set_t                 r_active;
  disp_set_t                 r_pending;
  logic                      r_pending_valid;
  logic [NUM_DIGITS-1:0]     r_an;
  logic [7:0]                r_cathodes;
  logic [IDX_W-1:0]          r_scan_idx;
  logic                      r_frame_tick;

  logic                      w_dwell_wrap;
  logic                      w_frame_edge;
  logic                      w_guard_ok;
  logic                      w_pwm_on;
  logic [NUM_DIGITS-1:0]     w_an;
  logic                      w_any_lit;
  logic [4:0]                w_sel_glyph;
  logic                      w_sel_dp;
  seg_t                      w_seg;
  disp_set_t                 w_load_set;

  assign w_dwell_wrap = (r_dwell_cnt == c_dwell_max);
  assign w_frame_edge = w_dwell_wrap && (r_cnt_idx == c_last_idx);
  assign w_guard_ok   = (r_dwell_cnt >= SCAN_DIV_BITS'(BLANK_CYCLES));
  // PWM compares against the top nibble so duty is in 1/16ths of a dwell
  assign w_pwm_on     = (r_active.bright > r_dwell_cnt[SCAN_DIV_BITS-1 -: 4]);
  assign w_any_lit    = ~&w_an;

  assign w_load_set = '{
    glyph:  bus.glyph_in,
    dp:     bus.dp_in,
    en:     bus.digit_en,
    blink:  bus.blink_en,
    bright: bus.brightness
  };

  always_comb begin
    w_an        = '1;
    w_sel_glyph = GLYPH_BLANK;
    w_sel_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_cnt_idx == IDX_W'(i)) begin
        w_sel_glyph = r_active.glyph[5*i +: 5];
        w_sel_dp    = r_active.dp[i];
        w_an[i]     = ~(r_active.en[i] & w_guard_ok & w_pwm_on &
                        ~(r_active.blink[i] & r_blink_phase));
      end
    end
  end

  ssd_glyph_decoder u_decoder (
    .i_glyph (w_sel_glyph),
    .o_seg   (w_seg)
  );

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dwell_cnt   <= '0;
      r_cnt_idx     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_dwell_cnt <= r_dwell_cnt + SCAN_DIV_BITS'(1);
      if (w_dwell_wrap) begin
        r_cnt_idx <= (r_cnt_idx == c_last_idx) ? '0 : r_cnt_idx + IDX_W'(1);
      end
      r_blink_cnt <= r_blink_cnt + BLINK_DIV_BITS'(1);
      if (&r_blink_cnt) begin
        r_blink_phase <= ~r_blink_phase;
      end
    end
  end

  // A load coincident with a frame edge still promotes the older pending set
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      r_active        <= c_set_reset;
      r_pending       <= c_set_reset;
      r_pending_valid <= 1'b0;
    end else begin
      if (w_frame_edge && r_pending_valid) begin
        r_active <= r_pending;
      end
      if (bus.load) begin
        r_pending       <= w_load_set;
        r_pending_valid <= 1'b1;
      end else if (w_frame_edge) begin
        r_pending_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      r_an         <= '1;
      r_cathodes   <= 8'hFF;
      r_scan_idx   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an;
      r_cathodes   <= w_any_lit ? {w_seg, ~w_sel_dp} : 8'hFF;
      r_scan_idx   <= r_cnt_idx;
      r_frame_tick <= w_frame_edge;
    end
  end

  assign bus.An         = r_an;
  assign bus.Cathodes   = r_cathodes;
  assign bus.scan_idx   = r_scan_idx;
  assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire
